// File: rtl/cnn_seq_ctrl_if.sv
// Host-side handshake and datapath control bundle for cnn_seq_ctrl.
// The host (master) drives start/abort; the sequencer (slave) drives everything else.
interface cnn_seq_ctrl_if #(
  parameter int unsigned RowW = 2,
  parameter int unsigned ColW = 2,
  parameter int unsigned CntW = 8
) ();

  logic            start;
  logic            abort;
  logic            busy;
  logic            done;
  logic [2:0]      state;
  logic [RowW-1:0] win_row;
  logic [ColW-1:0] win_col;
  logic [CntW-1:0] frame_cnt;
  logic            en_clk;
  logic            clr;
  logic            wr;
  logic            en_wr;
  logic            en_rd;
  logic            en_MAC;
  logic            en_MAC_out;
  logic            en_act;
  logic            en_act_out;
  logic            en_pool;
  logic            en_pool_out;

  modport master (
    output start, abort,
    input  busy, done, state, win_row, win_col, frame_cnt,
    input  en_clk, clr, wr, en_wr, en_rd, en_MAC, en_MAC_out,
    input  en_act, en_act_out, en_pool, en_pool_out
  );

  modport slave (
    input  start, abort,
    output busy, done, state, win_row, win_col, frame_cnt,
    output en_clk, clr, wr, en_wr, en_rd, en_MAC, en_MAC_out,
    output en_act, en_act_out, en_pool, en_pool_out
  );

endinterface

// File: rtl/cnn_seq_ctrl.sv
// Sequencer for the conv -> ReLU -> max-pool pipeline: one frame per accepted start.
// Every output is a flop; output flops are loaded from the next-state values so they
// line up with the state they describe.
module cnn_seq_ctrl #(
  parameter int unsigned R_Conv_Out = 3,
  parameter int unsigned C_Conv_Out = 3,
  parameter int unsigned MAC_CYC    = 9,
  parameter int unsigned POOL_CYC   = 4,
  parameter int unsigned Cnt_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  cnn_seq_ctrl_if.slave ctrl_io
);

  localparam int unsigned RowW  = (R_Conv_Out > 1) ? $clog2(R_Conv_Out) : 1;
  localparam int unsigned ColW  = (C_Conv_Out > 1) ? $clog2(C_Conv_Out) : 1;
  localparam int unsigned MacW  = (MAC_CYC > 1) ? $clog2(MAC_CYC) : 1;
  localparam int unsigned PoolW = (POOL_CYC > 1) ? $clog2(POOL_CYC) : 1;

  localparam logic [RowW-1:0]  RowLast  = RowW'(R_Conv_Out - 1);
  localparam logic [ColW-1:0]  ColLast  = ColW'(C_Conv_Out - 1);
  localparam logic [MacW-1:0]  MacLast  = MacW'(MAC_CYC - 1);
  localparam logic [PoolW-1:0] PoolLast = PoolW'(POOL_CYC - 1);

  // POOL_OUT and DONE share external code 7, so the internal encoding is wider.
  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StLoad,
    StConv,
    StAct,
    StActOut,
    StPool,
    StPoolOut,
    StDone
  } state_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en_clk;
    logic       clr;
    logic       wr;
    logic       en_wr;
    logic       en_rd;
    logic       en_mac;
    logic       en_mac_out;
    logic       en_act;
    logic       en_act_out;
    logic       en_pool;
    logic       en_pool_out;
    logic [2:0] state;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [MacW-1:0]  mac_q, mac_d;
  logic [PoolW-1:0] pool_q, pool_d;
  logic [Cnt_W-1:0] frame_q, frame_d;
  ctrl_t            ctrl_q, ctrl_d;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      mac_q   <= '0;
      pool_q  <= '0;
      frame_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mac_q   <= mac_d;
      pool_q  <= pool_d;
      frame_q <= frame_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next-state and counter update; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mac_d   = mac_q;
    pool_d  = pool_q;
    frame_d = frame_q;

    if (state_q != StIdle && ctrl_io.abort) begin
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
      mac_d   = '0;
      pool_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_io.start && !ctrl_io.abort) begin
            state_d = StClr;
          end
        end
        StClr: begin
          state_d = StLoad;
        end
        StLoad: begin
          state_d = StConv;
          row_d   = '0;
          col_d   = '0;
          mac_d   = '0;
        end
        StConv: begin
          if (mac_q == MacLast) begin
            mac_d = '0;
            if (col_q == ColLast) begin
              col_d = '0;
              if (row_q == RowLast) begin
                row_d   = '0;
                state_d = StAct;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            mac_d = mac_q + 1'b1;
          end
        end
        StAct: begin
          state_d = StActOut;
        end
        StActOut: begin
          state_d = StPool;
          pool_d  = '0;
        end
        StPool: begin
          if (pool_q == PoolLast) begin
            pool_d  = '0;
            state_d = StPoolOut;
          end else begin
            pool_d = pool_q + 1'b1;
          end
        end
        StPoolOut: begin
          state_d = StDone;
        end
        StDone: begin
          state_d = StIdle;
          frame_d = frame_q + 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered controls match state_q.
  always_comb begin
    ctrl_d        = '0;
    ctrl_d.busy   = (state_d != StIdle);
    ctrl_d.en_clk = (state_d != StIdle);
    case (state_d)
      StIdle: begin
        ctrl_d.state = 3'd0;
      end
      StClr: begin
        ctrl_d.state = 3'd1;
        ctrl_d.clr   = 1'b1;
      end
      StLoad: begin
        ctrl_d.state = 3'd2;
        ctrl_d.wr    = 1'b1;
        ctrl_d.en_wr = 1'b1;
      end
      StConv: begin
        ctrl_d.state      = 3'd3;
        ctrl_d.en_rd      = 1'b1;
        ctrl_d.en_mac     = 1'b1;
        ctrl_d.en_mac_out = (mac_d == MacLast);
      end
      StAct: begin
        ctrl_d.state  = 3'd4;
        ctrl_d.en_act = 1'b1;
      end
      StActOut: begin
        ctrl_d.state      = 3'd5;
        ctrl_d.en_act_out = 1'b1;
      end
      StPool: begin
        ctrl_d.state   = 3'd6;
        ctrl_d.en_pool = 1'b1;
      end
      StPoolOut: begin
        ctrl_d.state       = 3'd7;
        ctrl_d.en_pool_out = 1'b1;
      end
      StDone: begin
        ctrl_d.state = 3'd7;
        ctrl_d.done  = 1'b1;
      end
      default: begin
        ctrl_d = '0;
      end
    endcase
  end

  // Window counters sit at zero outside CONV, so they can drive the ports directly.
  assign ctrl_io.busy        = ctrl_q.busy;
  assign ctrl_io.done        = ctrl_q.done;
  assign ctrl_io.state       = ctrl_q.state;
  assign ctrl_io.win_row     = row_q;
  assign ctrl_io.win_col     = col_q;
  assign ctrl_io.frame_cnt   = frame_q;
  assign ctrl_io.en_clk      = ctrl_q.en_clk;
  assign ctrl_io.clr         = ctrl_q.clr;
  assign ctrl_io.wr          = ctrl_q.wr;
  assign ctrl_io.en_wr       = ctrl_q.en_wr;
  assign ctrl_io.en_rd       = ctrl_q.en_rd;
  assign ctrl_io.en_MAC      = ctrl_q.en_mac;
  assign ctrl_io.en_MAC_out  = ctrl_q.en_mac_out;
  assign ctrl_io.en_act      = ctrl_q.en_act;
  assign ctrl_io.en_act_out  = ctrl_q.en_act_out;
  assign ctrl_io.en_pool     = ctrl_q.en_pool;
  assign ctrl_io.en_pool_out = ctrl_q.en_pool_out;

endmodule
